// File: rtl/ic_bram_cpu_bus_bridge.sv
// ic_bram_cpu_bus_bridge
// Lets a BRAM-style master (cen/addr/wdata/wstrb, stall/rdata) act as an
// initiator on the CPU request/response bus. One transaction is kept in flight.
// The master stays stalled until the bus response has been captured. A response
// that does not arrive before the timeout is reported as an error. The late
// response is then absorbed as an "orphan" before any new request is issued.
module ic_bram_cpu_bus_bridge #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TW             = 16
) (
  input  logic        g_clk,
  input  logic        g_reset,
  input  logic        enable,
  input  logic        bram_cen,
  input  logic [31:0] bram_addr,
  input  logic [31:0] bram_wdata,
  input  logic [3:0]  bram_wstrb,
  output logic        bram_stall,
  output logic [31:0] bram_rdata,
  output logic        bram_error,
  output logic        mem_req,
  input  logic        mem_gnt,
  output logic        mem_wen,
  output logic [3:0]  mem_strb,
  output logic [31:0] mem_wdata,
  output logic [31:0] mem_addr,
  input  logic        mem_recv,
  output logic        mem_ack,
  input  logic        mem_error,
  input  logic [31:0] mem_rdata,
  output logic        busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RSP  = 2'd2,
    ST_ACC  = 2'd3
  } state_t;

  localparam logic [TW-1:0] TMO_LIMIT = TW'(TIMEOUT_CYCLES);
  localparam logic          TMO_EN    = (TIMEOUT_CYCLES != 0);

  state_t        state_r,  state_nxt_s;
  logic          orphan_r, orphan_nxt_s;
  logic [TW-1:0] cnt_r,    cnt_nxt_s;
  logic [31:0]   addr_r,   addr_nxt_s;
  logic [31:0]   wdata_r,  wdata_nxt_s;
  logic [3:0]    strb_r,   strb_nxt_s;
  logic          wen_r,    wen_nxt_s;
  logic [31:0]   rdata_r,  rdata_nxt_s;
  logic          error_r,  error_nxt_s;
  logic          req_r,    req_nxt_s;
  logic          ack_r,    ack_nxt_s;
  logic          stall_r,  stall_nxt_s;
  logic          busy_r,   busy_nxt_s;

  // Next-state, datapath capture, and the next values of the state-decoded outputs
  always_comb begin
    state_nxt_s  = state_r;
    orphan_nxt_s = orphan_r;
    cnt_nxt_s    = cnt_r;
    addr_nxt_s   = addr_r;
    wdata_nxt_s  = wdata_r;
    strb_nxt_s   = strb_r;
    wen_nxt_s    = wen_r;
    rdata_nxt_s  = rdata_r;
    error_nxt_s  = error_r;

    case (state_r)
      ST_IDLE: begin
        // A response that timed out still owes us one mem_recv; swallow it here
        if (orphan_r && mem_recv) begin
          orphan_nxt_s = 1'b0;
        end else begin
          orphan_nxt_s = orphan_r;
        end
        if (bram_cen && enable && !orphan_r) begin
          addr_nxt_s  = bram_addr;
          wdata_nxt_s = bram_wdata;
          strb_nxt_s  = bram_wstrb;
          wen_nxt_s   = |bram_wstrb;
          state_nxt_s = ST_REQ;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (mem_gnt) begin
          cnt_nxt_s   = {TW{1'b0}};
          state_nxt_s = ST_RSP;
        end else begin
          state_nxt_s = ST_REQ;
        end
      end
      ST_RSP: begin
        if (mem_recv) begin
          rdata_nxt_s = mem_rdata;
          error_nxt_s = mem_error;
          state_nxt_s = ST_ACC;
        end else if (TMO_EN && (cnt_r == TMO_LIMIT)) begin
          // Give up: report an error and remember that the bus still owes a response
          rdata_nxt_s  = 32'h0000_0000;
          error_nxt_s  = 1'b1;
          orphan_nxt_s = 1'b1;
          state_nxt_s  = ST_ACC;
        end else begin
          cnt_nxt_s   = cnt_r + TW'(1);
          state_nxt_s = ST_RSP;
        end
      end
      ST_ACC: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase

    req_nxt_s   = (state_nxt_s == ST_REQ);
    ack_nxt_s   = (state_nxt_s == ST_RSP) || ((state_nxt_s == ST_IDLE) && orphan_nxt_s);
    stall_nxt_s = (state_nxt_s != ST_ACC);
    busy_nxt_s  = (state_nxt_s != ST_IDLE) || orphan_nxt_s;
  end

  // State, request/capture registers and registered handshake outputs
  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      state_r  <= ST_IDLE;
      orphan_r <= 1'b0;
      cnt_r    <= {TW{1'b0}};
      addr_r   <= 32'h0000_0000;
      wdata_r  <= 32'h0000_0000;
      strb_r   <= 4'b0000;
      wen_r    <= 1'b0;
      rdata_r  <= 32'h0000_0000;
      error_r  <= 1'b0;
      req_r    <= 1'b0;
      ack_r    <= 1'b0;
      stall_r  <= 1'b1;
      busy_r   <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      orphan_r <= orphan_nxt_s;
      cnt_r    <= cnt_nxt_s;
      addr_r   <= addr_nxt_s;
      wdata_r  <= wdata_nxt_s;
      strb_r   <= strb_nxt_s;
      wen_r    <= wen_nxt_s;
      rdata_r  <= rdata_nxt_s;
      error_r  <= error_nxt_s;
      req_r    <= req_nxt_s;
      ack_r    <= ack_nxt_s;
      stall_r  <= stall_nxt_s;
      busy_r   <= busy_nxt_s;
    end
  end

  assign bram_stall = stall_r;
  assign bram_rdata = rdata_r;
  assign bram_error = error_r;
  assign mem_req    = req_r;
  assign mem_ack    = ack_r;
  assign mem_wen    = wen_r;
  assign mem_strb   = strb_r;
  assign mem_wdata  = wdata_r;
  assign mem_addr   = addr_r;
  assign busy       = busy_r;

endmodule
